lotr_eot_mbox: RTL and testbench

End-of-test mailbox for the lotr multi-core RISC-V fabric. Cores report completion and a pass/fail code by storing to memory-mapped status words. The block aggregates these into a single done/pass/fail indication plus a watchdog timeout, which the testbench samples to end simulation. It sits on the core data-memory request path as a write/read slave, and its outputs go to the top-level ports that face the bench.

---
 rtl/lotr_pkg.sv | 20 ++
 rtl/lotr_eot_watchdog.sv | 36 +++
 rtl/lotr_eot_mbox.sv | 131 +++++++++++++
 tb/tb_lotr_eot_mbox.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lotr_pkg.sv
// Shared types and address map constants for the lotr end-of-test mailbox.
package lotr_pkg;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_PASS    = 3'd1,
        ST_FAIL    = 3'd2,
        ST_TIMEOUT = 3'd3
    } eot_state_e;

    localparam logic [31:0] LOTR_BASE_ADDR = 32'h00C0_0000;
    localparam logic [31:0] OFS_SUMMARY    = 32'h0000_0040;
    localparam logic [31:0] OFS_COUNTER    = 32'h0000_0044;

    typedef struct packed {
        logic [30:0] code;
        logic        done;
    } mbox_word_t;

endpackage

// File: rtl/lotr_eot_watchdog.sv
// Saturating run-time counter with a single-compare expiry flag.
module lotr_eot_watchdog #(
    parameter logic [31:0] TIMEOUT_CYC = 32'd100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_en,
    output logic [31:0] count,
    output logic        expired
);
    logic        armed_q, armed_d;
    logic [31:0] count_q, count_d;

    // First edge after reset release only arms the counter, so counting restarts from 0.
    always_comb begin
        armed_d = 1'b1;
        count_d = count_q;
        if (armed_q && run_en && (count_q != '1)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_q <= 1'b0;
            count_q <= '0;
        end else begin
            armed_q <= armed_d;
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign expired = armed_q && (count_q == (TIMEOUT_CYC - 32'd1));

endmodule

// File: rtl/lotr_eot_mbox.sv
// End-of-test mailbox: per-core status words, pass/fail/timeout state and read-back window.
module lotr_eot_mbox
    import lotr_pkg::*;
#(
    parameter int unsigned NUM_CORES   = 4,
    parameter logic [31:0] BASE_ADDR   = LOTR_BASE_ADDR,
    parameter logic [31:0] TIMEOUT_CYC = 32'd100000
) (
    input  logic                 QClk,
    input  logic                 RstQnnnH,
    input  logic                 WrEnQ,
    input  logic                 RdEnQ,
    input  logic [31:0]          AddressQ,
    input  logic [31:0]          WrDataQ,
    output logic [31:0]          RdDataQ,
    output logic                 AllDoneQ,
    output logic                 PassQ,
    output logic                 TimeoutQ,
    output logic [NUM_CORES-1:0] CoreDoneQ
);
    localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    mbox_word_t            words_q [NUM_CORES];
    mbox_word_t            words_d [NUM_CORES];
    logic                  ovf_err_q, ovf_err_d;
    eot_state_e            state_q, state_d;
    logic [31:0]           rd_data_q, rd_data_d;
    logic [31:0]           offset;
    logic                  core_hit;
    logic [IDX_W-1:0]      core_idx;
    logic [NUM_CORES-1:0]  done_now, done_next;
    logic                  code_nz;
    logic [31:0]           wd_count;
    logic                  wd_expired;

    always_comb begin
        offset   = AddressQ - BASE_ADDR;
        core_hit = (offset < 32'(4 * NUM_CORES)) && (offset[1:0] == 2'b00);
        core_idx = offset[IDX_W+1:2];
    end

    always_comb begin
        words_d   = words_q;
        ovf_err_d = ovf_err_q;
        if (WrEnQ && core_hit) begin
            if (!words_q[core_idx].done && WrDataQ[0]) begin
                words_d[core_idx].code = WrDataQ[31:1];
                words_d[core_idx].done = 1'b1;
            end else begin
                ovf_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        done_now  = '0;
        done_next = '0;
        code_nz   = 1'b0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            done_now[i]  = words_q[i].done;
            done_next[i] = words_d[i].done;
            code_nz      = code_nz | (|words_q[i].code);
        end
    end

    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            words_q   <= '{default: '0};
            ovf_err_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            words_q   <= words_d;
            ovf_err_q <= ovf_err_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Completion is judged on registered flags; timeout is suppressed when a write in
    // this very cycle completes the set, so that write still resolves to PASS/FAIL.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN) begin
            if (&done_now) begin
                state_d = code_nz ? ST_FAIL : ST_PASS;
            end else if (wd_expired && !(&done_next)) begin
                state_d = ST_TIMEOUT;
            end
        end
    end

    always_comb begin
        AllDoneQ  = (state_q != ST_RUN);
        PassQ     = (state_q == ST_PASS);
        TimeoutQ  = (state_q == ST_TIMEOUT);
        CoreDoneQ = done_now;
    end

    lotr_eot_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (QClk),
        .rst     (RstQnnnH),
        .run_en  (state_d == ST_RUN),
        .count   (wd_count),
        .expired (wd_expired)
    );

    always_comb begin
        rd_data_d = '0;
        if (RdEnQ) begin
            if (core_hit) begin
                rd_data_d = words_q[core_idx];
            end else if (offset == OFS_SUMMARY) begin
                rd_data_d = {24'b0, ovf_err_q, state_q, TimeoutQ, PassQ, AllDoneQ, 1'b0};
            end else if (offset == OFS_COUNTER) begin
                rd_data_d = wd_count;
            end
        end
    end

    assign RdDataQ = rd_data_q;

endmodule

// File: tb/tb_lotr_eot_mbox.sv
// Directed bench for lotr_eot_mbox with a read-data scoreboard queue.
module tb_lotr_eot_mbox;
    localparam logic [31:0] BASE = 32'h00C0_0000;

    logic        QClk = 1'b0;
    logic        RstQnnnH = 1'b1;
    logic        WrEnQ = 1'b0;
    logic        RdEnQ = 1'b0;
    logic [31:0] AddressQ = '0;
    logic [31:0] WrDataQ = '0;
    logic [31:0] RdDataQ;
    logic        AllDoneQ, PassQ, TimeoutQ;
    logic [3:0]  CoreDoneQ;

    int          tests = 0;
    int          failures = 0;
    int          edge_n = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    lotr_eot_mbox #(
        .NUM_CORES   (4),
        .BASE_ADDR   (BASE),
        .TIMEOUT_CYC (32'd50)
    ) dut (
        .QClk      (QClk),
        .RstQnnnH  (RstQnnnH),
        .WrEnQ     (WrEnQ),
        .RdEnQ     (RdEnQ),
        .AddressQ  (AddressQ),
        .WrDataQ   (WrDataQ),
        .RdDataQ   (RdDataQ),
        .AllDoneQ  (AllDoneQ),
        .PassQ     (PassQ),
        .TimeoutQ  (TimeoutQ),
        .CoreDoneQ (CoreDoneQ)
    );

    always #5 QClk = ~QClk;

    initial begin
        #200000;
        $display("FAIL time_limit: observed no finish, expected finish before 200000");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge QClk);
        #1;
        edge_n++;
    endtask

    task automatic tick_to(input int n);
        while (edge_n < n) tick();
    endtask

    task automatic check_rd();
        if (exp_q.size() == 0) begin
            check("rd_queue_underflow", 32'd1, 32'd0);
        end else begin
            check(tag_q.pop_front(), RdDataQ, exp_q.pop_front());
        end
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        RdEnQ = 1'b1;
        AddressQ = addr;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        tick();
        RdEnQ = 1'b0;
        check_rd();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        WrEnQ = 1'b1;
        AddressQ = addr;
        WrDataQ = data;
        tick();
        WrEnQ = 1'b0;
    endtask

    // Asserts reset asynchronously, checks cleared outputs, holds 3 cycles, releases.
    task automatic do_reset(input string tag);
        RstQnnnH = 1'b1;
        WrEnQ = 1'b0;
        RdEnQ = 1'b0;
        #2;
        check({tag, "_alldone"}, {31'b0, AllDoneQ}, 32'd0);
        check({tag, "_pass"}, {31'b0, PassQ}, 32'd0);
        check({tag, "_timeout"}, {31'b0, TimeoutQ}, 32'd0);
        check({tag, "_coredone"}, {28'b0, CoreDoneQ}, 32'd0);
        check({tag, "_rddata"}, RdDataQ, 32'd0);
        repeat (3) @(posedge QClk);
        #1;
        RstQnnnH = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        logic [31:0] codes [4];

        // All cores pass; ignored writes to unmapped and summary addresses.
        do_reset("rst0");
        wr(BASE + 32'h10, 32'h1);
        wr(BASE + 32'h40, 32'hFF);
        tick_to(9);
        for (int i = 0; i < 4; i++) begin
            WrEnQ = 1'b1;
            AddressQ = BASE + 32'(4 * i);
            WrDataQ = 32'h1;
            if (i == 0) begin
                RdEnQ = 1'b1;
                exp_q.push_back(32'h0);
                tag_q.push_back("rd_old_same_cycle");
            end
            tick();
            if (i == 0) begin
                RdEnQ = 1'b0;
                check_rd();
            end
            check("pass_coredone_step", {28'b0, CoreDoneQ}, 32'((1 << (i + 1)) - 1));
            check("pass_alldone_early", {31'b0, AllDoneQ}, 32'd0);
        end
        WrEnQ = 1'b0;
        tick();
        check("pass_alldone", {31'b0, AllDoneQ}, 32'd1);
        check("pass_passq", {31'b0, PassQ}, 32'd1);
        check("pass_timeout", {31'b0, TimeoutQ}, 32'd0);
        rd(BASE + 32'h40, 32'h16, "pass_summary");
        rd(BASE + 32'h44, 32'd12, "pass_counter_frozen");
        rd(BASE + 32'h4, 32'h1, "pass_word1");
        rd(BASE + 32'h10, 32'h0, "unmapped_core4");
        rd(BASE + 32'h48, 32'h0, "unmapped_48");

        // Core 2 reports a nonzero code.
        do_reset("rst1");
        codes = '{32'h1, 32'h1, 32'h7, 32'h1};
        for (int i = 0; i < 4; i++) wr(BASE + 32'(4 * i), codes[i]);
        tick();
        check("fail_alldone", {31'b0, AllDoneQ}, 32'd1);
        check("fail_passq", {31'b0, PassQ}, 32'd0);
        check("fail_timeout", {31'b0, TimeoutQ}, 32'd0);
        rd(BASE + 32'h8, 32'h7, "fail_word2");
        RdEnQ = 1'b1;
        AddressQ = BASE + 32'h40;
        exp_q.push_back(32'h22);
        tag_q.push_back("fail_summary");
        tick();
        RdEnQ = 1'b0;
        check_rd();

        // Reset from FAIL, counter restart, fresh pass.
        do_reset("rst_fail");
        tick_to(5);
        rd(BASE + 32'h44, 32'd4, "restart_counter");
        for (int i = 0; i < 4; i++) wr(BASE + 32'(4 * i), 32'h1);
        tick();
        check("restart_passq", {31'b0, PassQ}, 32'd1);

        // Watchdog timeout with only core 0 reporting.
        do_reset("rst2");
        wr(BASE, 32'h1);
        tick_to(50);
        check("to_timeout_early", {31'b0, TimeoutQ}, 32'd0);
        check("to_alldone_early", {31'b0, AllDoneQ}, 32'd0);
        tick();
        check("to_timeout", {31'b0, TimeoutQ}, 32'd1);
        check("to_alldone", {31'b0, AllDoneQ}, 32'd1);
        check("to_passq", {31'b0, PassQ}, 32'd0);
        check("to_coredone", {28'b0, CoreDoneQ}, 32'h1);
        rd(BASE + 32'h44, 32'd49, "to_counter");
        repeat (5) tick();
        rd(BASE + 32'h44, 32'd49, "to_counter_frozen");
        rd(BASE + 32'h40, 32'h3A, "to_summary");

        // Second write to a done core sets the sticky error but keeps the code.
        do_reset("rst3");
        wr(BASE + 32'h4, 32'h1);
        wr(BASE + 32'h4, 32'h5);
        wr(BASE + 32'h0, 32'h1);
        wr(BASE + 32'h8, 32'h1);
        wr(BASE + 32'hC, 32'h1);
        tick();
        check("ovw_passq", {31'b0, PassQ}, 32'd1);
        rd(BASE + 32'h4, 32'h1, "ovw_word1");
        rd(BASE + 32'h40, 32'h96, "ovw_summary");

        // Final done write coincides with counter at TIMEOUT_CYC-1.
        do_reset("rst4");
        for (int i = 0; i < 3; i++) wr(BASE + 32'(4 * i), 32'h1);
        tick_to(50);
        WrEnQ = 1'b1;
        AddressQ = BASE + 32'hC;
        WrDataQ = 32'h1;
        tick();
        WrEnQ = 1'b0;
        check("race_timeout_early", {31'b0, TimeoutQ}, 32'd0);
        check("race_coredone", {28'b0, CoreDoneQ}, 32'hF);
        check("race_alldone_early", {31'b0, AllDoneQ}, 32'd0);
        tick();
        check("race_passq", {31'b0, PassQ}, 32'd1);
        check("race_timeout", {31'b0, TimeoutQ}, 32'd0);
        rd(BASE + 32'h44, 32'd50, "race_counter");

        check("rd_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
